// File: rtl/ctrl_pipe.sv
// ID-stage control decoder for RV32I(+M) with a registered ID/EX control bundle.
// Also generates the load-use and MDU-occupancy front-end stalls and handles flush.
module ctrl_pipe #(
    parameter bit ENABLE_M    = 1'b1,
    parameter int MDU_LATENCY = 8,
    parameter int REG_AW      = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [31:0]       id_inst,
    input  logic              flush,
    output logic [4:0]        id_EXTOp,
    output logic              stall_front,
    output logic              ex_valid,
    output logic              ex_RegWrite,
    output logic              ex_MemWrite,
    output logic              ex_Memread,
    output logic              ex_ALUSrc,
    output logic              ex_Zero_1,
    output logic [4:0]        ex_ALUOp,
    output logic [1:0]        ex_NPCOp,
    output logic [1:0]        ex_WDSel,
    output logic [3:0]        ex_ls,
    output logic [REG_AW-1:0] ex_rd,
    output logic              ex_illegal,
    output logic              mdu_start,
    output logic              mdu_busy
);
    localparam logic [4:0] ALU_NOP = 5'd0,  ALU_ADD = 5'd1,  ALU_SUB = 5'd2,  ALU_AND = 5'd3;
    localparam logic [4:0] ALU_OR  = 5'd4,  ALU_XOR = 5'd5,  ALU_SL  = 5'd6,  ALU_SRL = 5'd7;
    localparam logic [4:0] ALU_SRA = 5'd8,  ALU_LT  = 5'd9,  ALU_LTU = 5'd10, ALU_B   = 5'd11;
    localparam logic [4:0] ALU_MUL = 5'd12;
    localparam logic [4:0] EXT_I = 5'b10000, EXT_S = 5'b01000, EXT_B = 5'b00100;
    localparam logic [4:0] EXT_U = 5'b00010, EXT_J = 5'b00001, EXT_SH = 5'b11111;
    localparam logic       S_IDLE = 1'b0, S_BUSY = 1'b1;
    localparam bit         LONG = (MDU_LATENCY > 1);
    localparam logic [4:0] CNT_INIT = LONG ? 5'(MDU_LATENCY - 2) : 5'd0;

    logic [6:0] f7, opc;
    logic [2:0] f3;
    assign f7  = id_inst[31:25];
    assign f3  = id_inst[14:12];
    assign opc = id_inst[6:0];

    logic             legal, use_rs1, use_rs2;
    logic             d_rw, d_mw, d_mr, d_asrc, d_z;
    logic [4:0]       d_alu, d_ext;
    logic [1:0]       d_npc, d_wd;
    logic [3:0]       d_ls;
    logic [REG_AW-1:0] d_rd;

    function automatic logic [4:0] alu_base(input logic [2:0] f);
        case (f)
            3'd0: alu_base = ALU_ADD;
            3'd1: alu_base = ALU_SL;
            3'd2: alu_base = ALU_LT;
            3'd3: alu_base = ALU_LTU;
            3'd4: alu_base = ALU_XOR;
            3'd5: alu_base = ALU_SRL;
            3'd6: alu_base = ALU_OR;
            default: alu_base = ALU_AND;
        endcase
    endfunction

    always_comb begin
        legal = 1'b0; use_rs1 = 1'b0; use_rs2 = 1'b0;
        d_rw = 1'b0; d_mw = 1'b0; d_mr = 1'b0; d_asrc = 1'b0; d_z = 1'b0;
        d_alu = ALU_NOP; d_ext = 5'b0; d_npc = 2'b00; d_wd = 2'b00; d_ls = 4'b0;
        case (opc)
            7'b0110011: begin
                use_rs1 = 1'b1; use_rs2 = 1'b1; d_rw = 1'b1;
                if (f7 == 7'b0000001) begin
                    legal = ENABLE_M;
                    d_alu = ALU_MUL + {2'b00, f3};
                end else if (f7 == 7'b0000000) begin
                    legal = 1'b1;
                    d_alu = alu_base(f3);
                end else if (f7 == 7'b0100000 && (f3 == 3'd0 || f3 == 3'd5)) begin
                    legal = 1'b1;
                    d_alu = (f3 == 3'd0) ? ALU_SUB : ALU_SRA;
                end
            end
            7'b0010011: begin
                use_rs1 = 1'b1; d_rw = 1'b1; d_asrc = 1'b1; d_ext = EXT_I;
                d_alu = alu_base(f3); legal = 1'b1;
                if (f3 == 3'd1) begin
                    d_ext = EXT_SH;
                    legal = (f7 == 7'b0000000);
                end else if (f3 == 3'd5) begin
                    d_ext = EXT_SH;
                    if (f7 == 7'b0100000) d_alu = ALU_SRA;
                    else if (f7 != 7'b0000000) legal = 1'b0;
                end
            end
            7'b0000011: begin
                use_rs1 = 1'b1; d_rw = 1'b1; d_mr = 1'b1; d_asrc = 1'b1;
                d_alu = ALU_ADD; d_wd = 2'b01; d_ext = EXT_I; legal = 1'b1;
                case (f3)
                    3'd2: d_ls = 4'b0000;
                    3'd1: d_ls = 4'b1000;
                    3'd0: d_ls = 4'b0100;
                    3'd5: d_ls = 4'b0010;
                    3'd4: d_ls = 4'b0001;
                    default: legal = 1'b0;
                endcase
            end
            7'b0100011: begin
                use_rs1 = 1'b1; use_rs2 = 1'b1; d_mw = 1'b1; d_asrc = 1'b1;
                d_alu = ALU_ADD; d_ext = EXT_S; legal = 1'b1;
                case (f3)
                    3'd2: d_ls = 4'b0000;
                    3'd1: d_ls = 4'b1000;
                    3'd0: d_ls = 4'b0100;
                    default: legal = 1'b0;
                endcase
            end
            7'b1100011: begin
                // Zero_1 marks branches taken when the ALU result is zero
                use_rs1 = 1'b1; use_rs2 = 1'b1; d_npc = 2'b01; d_ext = EXT_B; legal = 1'b1;
                case (f3)
                    3'd0: begin d_alu = ALU_SUB; d_z = 1'b1; end
                    3'd1: d_alu = ALU_SUB;
                    3'd4: d_alu = ALU_LT;
                    3'd5: begin d_alu = ALU_LT;  d_z = 1'b1; end
                    3'd6: d_alu = ALU_LTU;
                    3'd7: begin d_alu = ALU_LTU; d_z = 1'b1; end
                    default: legal = 1'b0;
                endcase
            end
            7'b0110111: begin
                d_rw = 1'b1; d_asrc = 1'b1; d_alu = ALU_B; d_ext = EXT_U; legal = 1'b1;
            end
            7'b0010111: begin
                d_rw = 1'b1; d_wd = 2'b11; d_ext = EXT_U; legal = 1'b1;
            end
            7'b1101111: begin
                d_rw = 1'b1; d_npc = 2'b10; d_wd = 2'b10; d_ext = EXT_J; legal = 1'b1;
            end
            7'b1100111: begin
                use_rs1 = 1'b1; d_rw = 1'b1; d_npc = 2'b11; d_wd = 2'b10; d_asrc = 1'b1;
                d_alu = ALU_ADD; d_ext = EXT_I; legal = (f3 == 3'd0);
            end
            default: ;
        endcase
    end

    assign d_rd     = d_rw ? REG_AW'(id_inst[11:7]) : '0;
    assign id_EXTOp = d_ext;

    logic       state;
    logic [4:0] cnt;
    logic       ex_is_m, mdu_first, hold, lu, load_id, take;

    assign ex_is_m   = (ex_ALUOp >= ALU_MUL);
    assign mdu_first = ex_valid & ex_is_m & (state == S_IDLE);
    assign hold      = (mdu_first & LONG) | ((state == S_BUSY) & (cnt != 5'd0));
    assign lu        = ex_valid & ex_Memread & (ex_rd != '0) & id_valid &
                       ((use_rs1 & (REG_AW'(id_inst[19:15]) == ex_rd)) |
                        (use_rs2 & (REG_AW'(id_inst[24:20]) == ex_rd)));
    assign stall_front = ~flush & (hold | lu);
    assign load_id   = ~flush & ~hold & ~lu;
    assign take      = load_id & id_valid & legal;
    assign mdu_start = mdu_first;
    assign mdu_busy  = (state == S_BUSY);

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid <= 1'b0; ex_RegWrite <= 1'b0; ex_MemWrite <= 1'b0; ex_Memread <= 1'b0;
            ex_ALUSrc <= 1'b0; ex_Zero_1 <= 1'b0; ex_ALUOp <= '0; ex_NPCOp <= '0;
            ex_WDSel <= '0; ex_ls <= '0; ex_rd <= '0; ex_illegal <= 1'b0;
        end else if (flush || !hold) begin
            ex_valid    <= take;
            ex_RegWrite <= take & d_rw;
            ex_MemWrite <= take & d_mw;
            ex_Memread  <= take & d_mr;
            ex_ALUSrc   <= take & d_asrc;
            ex_Zero_1   <= take & d_z;
            ex_ALUOp    <= take ? d_alu : '0;
            ex_NPCOp    <= take ? d_npc : '0;
            ex_WDSel    <= take ? d_wd  : '0;
            ex_ls       <= take ? d_ls  : '0;
            ex_rd       <= take ? d_rd  : '0;
            ex_illegal  <= load_id & id_valid & ~legal;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state <= S_IDLE;
            cnt   <= 5'd0;
        end else if (state == S_IDLE) begin
            if (mdu_first && LONG) begin
                state <= S_BUSY;
                cnt   <= CNT_INIT;
            end
        end else if (cnt == 5'd0) begin
            state <= S_IDLE;
        end else begin
            cnt <= cnt - 5'd1;
        end
    end
endmodule
